// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multi-cycle control FSM for the 32-bit datapath; drives ALU,
//            datapath muxes and write enables; counts retired instructions.
//            Optional memory wait states: define MULTICYCLE_MEM_WAIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic                 mem_ready,
`endif
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic [3:0]           alu_sel,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 i_or_d,
  output logic                 ir_we,
  output logic                 mem_we,
  output logic                 reg_we,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 retire;
  logic                 mem_ok;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    state_d    = FETCH;
    retire     = 1'b0;
    alu_sel    = 4'd2;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    i_or_d     = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_we     = mem_ok;
        pc_we     = mem_ok;
        state_d   = mem_ok ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target is precomputed here into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                      state_d = MEM_ADDR;
          OP_RTYPE:                          state_d = R_EXEC;
          OP_BEQ, OP_BNE:                    state_d = BRANCH;
          OP_J:                              state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = I_EXEC;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        i_or_d  = 1'b1;
        state_d = mem_ok ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      MEM_WRITE: begin
        i_or_d  = 1'b1;
        mem_we  = mem_ok;
        retire  = mem_ok;
        state_d = mem_ok ? FETCH : MEM_WRITE;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = R_WB;
        case (funct)
          6'h20:   alu_sel = 4'd2;
          6'h22:   alu_sel = 4'd3;
          6'h24:   alu_sel = 4'd4;
          6'h25:   alu_sel = 4'd5;
          6'h27:   alu_sel = 4'd6;
          6'h2A:   alu_sel = 4'd7;
          6'h00:   alu_sel = 4'd8;
          6'h02:   alu_sel = 4'd9;
          default: begin
            alu_sel = 4'd0;
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      R_WB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        retire  = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_sel   = 4'd3;
        pc_src    = 2'b01;
        pc_we     = (opcode == OP_BNE) ? ~zero : zero;
        retire    = 1'b1;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = I_WB;
        case (opcode)
          OP_ANDI: alu_sel = 4'd4;
          OP_ORI:  alu_sel = 4'd5;
          OP_SLTI: alu_sel = 4'd7;
          default: alu_sel = 4'd2;
        endcase
      end
      I_WB: begin
        reg_we = 1'b1;
        retire = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    // Reset aborts any in-flight instruction: no architectural writes.
    if (rst) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      mem_we  = 1'b0;
      reg_we  = 1'b0;
      illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Directed self-checking bench for multicycle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          mem_ready;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic          zero;
    logic [3:0]    alu_sel;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic          pc_we;
    logic [1:0]    pc_src;
    logic          i_or_d;
    logic          ir_we;
    logic          mem_we;
    logic          reg_we;
    logic          reg_dst;
    logic          mem_to_reg;
    logic          illegal;
    logic [3:0]    state;
    logic [CW-1:0] instr_count;

    int n_cmp;
    int n_err;

    multicycle_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef MULTICYCLE_MEM_WAIT_EN
        .mem_ready   (mem_ready),
`endif
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .alu_sel     (alu_sel),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .i_or_d      (i_or_d),
        .ir_we       (ir_we),
        .mem_we      (mem_we),
        .reg_we      (reg_we),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .illegal     (illegal),
        .state       (state),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h20;
        zero      = 1'b0;

        // Reset held for two edges
        tick();
        check("rst_state", state, 4'd0);
        check("rst_pc_we", pc_we, 1'b0);
        check("rst_ir_we", ir_we, 1'b0);
        check("rst_count", instr_count, 4'd0);
        tick();
        check("rst_reg_we", reg_we, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        rst = 1'b0;
        #1;
        check("fetch_pc_we", pc_we, 1'b1);
        check("fetch_ir_we", ir_we, 1'b1);
        check("fetch_alu_sel", alu_sel, 4'd2);
        check("fetch_src_b", alu_src_b, 2'b01);

        // lw: 0,1,2,3,4,0
        opcode = 6'h23;
        tick();
        check("lw_s1", state, 4'd1);
        check("lw_dec_src_b", alu_src_b, 2'b11);
        tick();
        check("lw_s2", state, 4'd2);
        check("lw_addr_src_a", alu_src_a, 1'b1);
        check("lw_addr_src_b", alu_src_b, 2'b10);
        tick();
        check("lw_s3", state, 4'd3);
        check("lw_rd_i_or_d", i_or_d, 1'b1);
        check("lw_rd_reg_we", reg_we, 1'b0);
        tick();
        check("lw_s4", state, 4'd4);
        check("lw_wb_reg_we", reg_we, 1'b1);
        check("lw_wb_m2r", mem_to_reg, 1'b1);
        check("lw_wb_count", instr_count, 4'd0);
        tick();
        check("lw_s0", state, 4'd0);
        check("lw_count", instr_count, 4'd1);
        check("lw_s0_reg_we", reg_we, 1'b0);

        // R-type slt
        opcode = 6'h00; funct = 6'h2A;
        tick(); tick();
        check("slt_s6", state, 4'd6);
        check("slt_alu_sel", alu_sel, 4'd7);
        check("slt_illegal", illegal, 1'b0);
        tick();
        check("slt_s7", state, 4'd7);
        check("slt_reg_dst", reg_dst, 1'b1);
        check("slt_reg_we", reg_we, 1'b1);
        tick();
        check("slt_count", instr_count, 4'd2);

        // R-type srl
        funct = 6'h02;
        tick(); tick();
        check("srl_alu_sel", alu_sel, 4'd9);
        tick(); tick();
        check("srl_s0", state, 4'd0);
        check("srl_count", instr_count, 4'd3);

        // R-type unsupported funct
        funct = 6'h3F;
        tick(); tick();
        check("badf_s6", state, 4'd6);
        check("badf_illegal", illegal, 1'b1);
        check("badf_alu_sel", alu_sel, 4'd0);
        tick();
        check("badf_s0", state, 4'd0);
        check("badf_illegal_off", illegal, 1'b0);
        check("badf_count", instr_count, 4'd3);

        // beq taken
        opcode = 6'h04; zero = 1'b1;
        tick(); tick();
        check("beq_s8", state, 4'd8);
        check("beq_pc_we", pc_we, 1'b1);
        check("beq_pc_src", pc_src, 2'b01);
        check("beq_alu_sel", alu_sel, 4'd3);
        tick();
        check("beq_s0", state, 4'd0);
        check("beq_count", instr_count, 4'd4);

        // bne with zero=1: not taken, still retires
        opcode = 6'h05;
        tick(); tick();
        check("bne_pc_we", pc_we, 1'b0);
        tick();
        check("bne_s0", state, 4'd0);
        check("bne_count", instr_count, 4'd5);
        zero = 1'b0;

        // j
        opcode = 6'h02;
        tick(); tick();
        check("j_s9", state, 4'd9);
        check("j_pc_src", pc_src, 2'b10);
        check("j_pc_we", pc_we, 1'b1);
        tick();
        check("j_count", instr_count, 4'd6);

        // ori
        opcode = 6'h0D;
        tick(); tick();
        check("ori_s10", state, 4'd10);
        check("ori_alu_sel", alu_sel, 4'd5);
        check("ori_src_b", alu_src_b, 2'b10);
        tick();
        check("ori_s11", state, 4'd11);
        check("ori_reg_we", reg_we, 1'b1);
        check("ori_reg_dst", reg_dst, 1'b0);
        tick();
        check("ori_count", instr_count, 4'd7);

        // Unsupported opcode
        opcode = 6'h3F;
        tick();
        check("badop_s1", state, 4'd1);
        check("badop_illegal", illegal, 1'b1);
        tick();
        check("badop_s0", state, 4'd0);
        check("badop_illegal_off", illegal, 1'b0);
        check("badop_count", instr_count, 4'd7);

        // sw
        opcode = 6'h2B;
        tick(); tick(); tick();
        check("sw_s5", state, 4'd5);
        check("sw_mem_we", mem_we, 1'b1);
        check("sw_i_or_d", i_or_d, 1'b1);
        tick();
        check("sw_s0", state, 4'd0);
        check("sw_count", instr_count, 4'd8);

        // lw aborted by reset in MEM_READ
        opcode = 6'h23;
        tick(); tick(); tick();
        check("abort_s3", state, 4'd3);
        rst = 1'b1;
        #1;
        check("abort_reg_we", reg_we, 1'b0);
        tick();
        check("abort_s0", state, 4'd0);
        check("abort_reg_we2", reg_we, 1'b0);
        check("abort_count", instr_count, 4'd0);
        rst = 1'b0;
        tick();
        check("abort_restart_s1", state, 4'd1);

        // Counter wraps after 16 jumps
        opcode = 6'h02;
        tick(); tick();
        for (int i = 0; i < 14; i++) begin
            tick(); tick(); tick();
        end
        check("wrap_pre", instr_count, 4'd15);
        tick(); tick(); tick();
        check("wrap_zero", instr_count, 4'd0);

`ifdef MULTICYCLE_MEM_WAIT_EN
        // sw held in MEM_WRITE for three cycles
        opcode = 6'h2B;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        check("hold_s5_a", state, 4'd5);
        check("hold_mem_we_a", mem_we, 1'b0);
        tick();
        check("hold_s5_b", state, 4'd5);
        check("hold_mem_we_b", mem_we, 1'b0);
        tick();
        check("hold_s5_c", state, 4'd5);
        check("hold_mem_we_c", mem_we, 1'b0);
        tick();
        mem_ready = 1'b1;
        #1;
        check("hold_s5_d", state, 4'd5);
        check("hold_mem_we_d", mem_we, 1'b1);
        tick();
        check("hold_s0", state, 4'd0);
        check("hold_count", instr_count, 4'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit for the 32-bit datapath; the initiator that drives the ALU.
- Sequences fetch/decode/execute/memory/writeback from the instruction opcode and funct fields.
- Issues the 4-bit ALU operation select and all datapath mux and write-enable controls.
- Consumes the ALU zero flag to resolve branches.
- Counts retired instructions and flags unsupported encodings.

Parameters:
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- opcode  input  6  instruction bits [31:26], from the instruction register.
- funct  input  6  instruction bits [5:0], from the instruction register.
- zero  input  1  ALU zero flag; 1 when the ALU result is 0.
- alu_sel  output  4  ALU operation: 0 passA, 1 passB, 2 add, 3 sub, 4 and, 5 or, 6 nor, 7 slt, 8 sll, 9 srl.
- alu_src_a  output  1  ALU A operand: 0 = PC, 1 = register A.
- alu_src_b  output  2  ALU B operand: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- pc_we  output  1  PC write enable.
- pc_src  output  2  PC source: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut.
- ir_we  output  1  instruction register write enable.
- mem_we  output  1  data memory write enable.
- reg_we  output  1  register file write enable.
- reg_dst  output  1  write-register select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write-back data: 0 = ALUOut, 1 = memory data register.
- illegal  output  1  one-cycle pulse on an unsupported opcode or funct.
- state  output  4  current state, for debug.
- instr_count  output  CNT_WIDTH  number of retired instructions.

Behaviour:
State register and sequencing:
- state is the only control register. Outputs are decoded combinationally from state, plus opcode/funct/zero where listed.
- While rst is 1 at a clock edge: next state = FETCH (0), instr_count = 0.
- While rst is high, all enables (pc_we, ir_we, mem_we, reg_we) and illegal are forced to 0.
- Reset asserted mid-instruction aborts that instruction with no further writes.
- Any unlisted state encoding goes to FETCH on the next edge.
- Any output not listed for a state defaults to 0, except alu_sel, which defaults to 2.

States (code: outputs -> next state):
- FETCH(0): i_or_d=0, ir_we=1, alu_src_a=0, alu_src_b=01, alu_sel=2, pc_src=00, pc_we=1 -> DECODE.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_sel=2 (precomputes branch target). Next state by opcode:
  - 0x23 (lw) or 0x2B (sw) -> MEM_ADDR.
  - 0x00 (R-type) -> R_EXEC.
  - 0x04 (beq) or 0x05 (bne) -> BRANCH.
  - 0x02 (j) -> JUMP.
  - 0x08 (addi), 0x0C (andi), 0x0D (ori), 0x0A (slti) -> I_EXEC.
  - Any other opcode: illegal=1 in this cycle -> FETCH.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_sel=2 -> MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ(3): i_or_d=1 -> MEM_WB.
- MEM_WB(4): reg_we=1, reg_dst=0, mem_to_reg=1 -> FETCH (retire).
- MEM_WRITE(5): i_or_d=1, mem_we=1 -> FETCH (retire).
- R_EXEC(6): alu_src_a=1, alu_src_b=00. alu_sel by funct:
  - 0x20 -> 2, 0x22 -> 3, 0x24 -> 4, 0x25 -> 5, 0x27 -> 6, 0x2A -> 7, 0x00 -> 8, 0x02 -> 9.
  - Any other funct: alu_sel=0, illegal=1, next state FETCH, no retire.
  - Valid funct -> R_WB.
- R_WB(7): reg_we=1, reg_dst=1, mem_to_reg=0 -> FETCH (retire).
- BRANCH(8): alu_src_a=1, alu_src_b=00, alu_sel=3, pc_src=01. pc_we = zero for beq, ~zero for bne -> FETCH (retire whether or not taken).
- JUMP(9): pc_src=10, pc_we=1 -> FETCH (retire).
- I_EXEC(10): alu_src_a=1, alu_src_b=10. alu_sel: addi -> 2, andi -> 4, ori -> 5, slti -> 7 -> I_WB.
- I_WB(11): reg_we=1, reg_dst=0, mem_to_reg=0 -> FETCH (retire).

Retire and counter:
- "Retire" means instr_count increments by 1 on the clock edge that leaves that state.
- instr_count wraps from all-ones to 0.

Latency (cycles per instruction, rst low):
- lw 5.
- R-type, addi/andi/ori/slti, sw: 4.
- beq/bne, j: 3.

Optional Feature:
- Macro: MULTICYCLE_MEM_WAIT_EN.
- When defined, input port mem_ready (1 bit) is added.
- FETCH, MEM_READ and MEM_WRITE hold their state and outputs until mem_ready=1.
- While holding, ir_we, pc_we and mem_we are gated by mem_ready; the state advances on the edge where mem_ready=1.
- When not defined: no port, and these states always last exactly 1 cycle.

Test Plan:
- Reset: assert rst for 2 cycles, release -> state=0, instr_count=0, enables 0 during reset; first cycle after release pc_we=1, ir_we=1, alu_sel=2, alu_src_b=01.
- lw (opcode 0x23): state sequence 0,1,2,3,4,0; reg_we=1 and mem_to_reg=1 only in state 4; instr_count +1.
- R-type funct 0x2A: state 6 gives alu_sel=7; funct 0x02 gives alu_sel=9; funct 0x3F -> illegal=1 for one cycle, return to FETCH, instr_count unchanged.
- beq with zero=1 -> pc_we=1 and pc_src=01 in state 8; bne with zero=1 -> pc_we=0; both retire in 3 cycles.
- Opcode 0x3F -> illegal pulse in DECODE, next state 0. rst asserted during state 3 -> state 0 next edge, reg_we never asserted for that lw.
- With MULTICYCLE_MEM_WAIT_EN: sw with mem_ready low for 3 cycles in MEM_WRITE -> mem_we=0 during the hold, then one mem_we=1 cycle -> FETCH.
